ibus_initiator: RTL and testbench
=================================

# ibus_initiator

Single-outstanding IBUS initiator that turns a simple command/acknowledge request from an internal engine (DMA channel, debug port) into IBUS master cycles toward the on-chip peripheral register blocks. It performs big-endian byte-lane generation, write-data replication, read-data right-justification and alignment checking, then returns status and data to the requester. Lives beside the CPU bus arbiter on the CE_R/CE_F phased internal bus.

## Interface
- TIMEOUT, 255, CE_R ticks a slave may hold IBUS_BUSY before abort (1..255; 8-bit counter)
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE_R  in  1  rising-phase clock enable; all state advances on CLK edges with CE_R=1
- CE_F  in  1  falling-phase enable; unused internally, defines slave read-data phase
- RES_N  in  1  synchronous soft reset, sampled on CE_R
- CMD_REQ  in  1  command valid; held with command fields stable until CMD_ACK
- CMD_A  in  28  byte address
- CMD_WE  in  1  1=write, 0=read
- CMD_SZ  in  2  0=byte, 1=word, 2=long, 3=reserved
- CMD_WD  in  32  write data, right-justified
- CMD_ACK  out  1  one-CLK completion pulse
- CMD_RD  out  32  read data, right-justified, zero-extended; valid with CMD_ACK
- CMD_AERR  out  1  address/size error; valid with CMD_ACK
- CMD_BERR  out  1  bus timeout error; valid with CMD_ACK
- IBUS_A  out  28  bus address
- IBUS_DO  out  32  bus write data
- IBUS_DI  in  32  bus read data
- IBUS_BA  out  4  byte-lane enables, BA[3]=bits 31:24
- IBUS_WE  out  1  write strobe
- IBUS_REQ  out  1  cycle request
- IBUS_BUSY  in  1  slave wait

## Operation
- States: IDLE, BUS. All IBUS outputs registered; idle values A=0, DO=0, BA=0, WE=0, REQ=0.
- IDLE, CE_R edge, CMD_REQ=1: check alignment. Error if SZ=3, SZ=1 with A[0]=1, SZ=2 with A[1:0]!=0 -> CMD_ACK=1, CMD_AERR=1, CMD_RD=0, no bus cycle, stay IDLE. Otherwise load IBUS_A=CMD_A, WE, BA, DO, REQ=1, clear timeout counter, go BUS.
- Lanes (big-endian): byte A[1:0]=0..3 -> BA 1000/0100/0010/0001; word A[1]=0 -> 1100, A[1]=1 -> 0011; long -> 1111.
- Write data replication: byte -> {4{WD[7:0]}}; word -> {2{WD[15:0]}}; long -> WD. Read: DO=0.
- BUS, CE_R edge, IBUS_BUSY=0: complete. Reads select the addressed lane(s) of IBUS_DI, shift to bits 0 up, zero-extend into CMD_RD. Writes: CMD_RD=0. CMD_ACK=1, errors 0, IBUS outputs to idle values, go IDLE.
- BUS, CE_R edge, IBUS_BUSY=1: hold all IBUS outputs; increment timeout counter (see Configuration).
- RES_N=0 at CE_R edge: any state -> IDLE, IBUS outputs idle, no CMD_ACK, counter cleared. Aborted command is lost; requester must reissue.
- CMD_REQ=0 in IDLE: nothing happens. CMD_* ignored outside IDLE.

## Timing
- Reset (RST_N low): state IDLE, all outputs 0.
- CMD_ACK, CMD_AERR, CMD_BERR registered on completing CE_R edge, cleared on next CLK edge (one CLK wide). CMD_RD holds until next completion.
- Zero-wait transfer: command accepted at CE_R edge n (REQ rises), slave drives read data on CE_F between, completion and capture at CE_R edge n+1. Slave samples writes at edge n+1.
- Each BUSY=1 sample adds one CE_R period.
- Back-to-back: after ACK the requester drops/changes CMD_REQ; earliest next acceptance at CE_R edge n+2 (REQ low for exactly one CE_R period between cycles).
- AERR path: ACK at the accepting CE_R edge, zero bus cycles.

## Configuration
- IBUS_TIMEOUT_EN defined: in BUS, counter increments per CE_R edge with BUSY=1; on the edge where BUSY=1 and counter==TIMEOUT-1 (i.e. TIMEOUT consecutive busy samples), abort: IBUS outputs idle, CMD_ACK=1, CMD_BERR=1, CMD_RD=0, go IDLE.
- Not defined: counter and abort logic absent; initiator waits indefinitely; CMD_BERR tied 0.

## Test plan
- Byte write A=5FFFF91, WD=000000A5 -> one cycle: BA=0100, DO=A5A5A5A5, WE=1, REQ high exactly one CE_R period; ACK, no errors.
- Long read A=5FFFF94, IBUS_DI=12345678, BUSY=0 -> ACK at 2nd CE_R edge, CMD_RD=12345678; word read A=5FFFF96 same DI -> BA=0011, CMD_RD=00005678.
- Misaligned: word A=...1 and long A=...2 and SZ=3 -> ACK+AERR same edge, IBUS_REQ never rises.
- BUSY held 3 CE_R edges on read -> A/BA/REQ stable throughout, ACK on 4th edge after acceptance, data captured only then.
- IBUS_TIMEOUT_EN, TIMEOUT=4, BUSY stuck 1 -> ACK+BERR after 4 busy samples, REQ low; without macro, no ACK after 300 edges.
- RES_N pulsed low while BUS with BUSY=1 -> REQ drops at that edge, no ACK; next command completes normally.

Source files
------------

// File: rtl/ibus_initiator_if.sv
// IBUS master-side signal bundle. The initiator uses the master modport and a
// peripheral or its model uses the slave modport.
interface ibus_initiator_if;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [31:0] IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;

  modport master (
    output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DI, IBUS_BUSY
  );

  modport slave (
    input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DI, IBUS_BUSY
  );
endinterface

// File: rtl/ibus_initiator.sv
// Single-outstanding IBUS initiator with big-endian lane generation and read right-justification.
// Define IBUS_TIMEOUT_EN to abort a cycle after TIMEOUT consecutive IBUS_BUSY samples.
module ibus_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   CE_R,
  input  logic                   CE_F,
  input  logic                   RES_N,
  input  logic                   CMD_REQ,
  input  logic [27:0]            CMD_A,
  input  logic                   CMD_WE,
  input  logic [1:0]             CMD_SZ,
  input  logic [31:0]            CMD_WD,
  output logic                   CMD_ACK,
  output logic [31:0]            CMD_RD,
  output logic                   CMD_AERR,
  output logic                   CMD_BERR,
  ibus_initiator_if.master       ibus
);

  typedef enum logic {IDLE, BUS} state_e;

  state_e      state_q, state_d;
  logic [27:0] ibus_a_q, ibus_a_d;
  logic [31:0] ibus_do_q, ibus_do_d;
  logic [3:0]  ibus_ba_q, ibus_ba_d;
  logic        ibus_we_q, ibus_we_d;
  logic        ibus_req_q, ibus_req_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        cmd_aerr_q, cmd_aerr_d;
  logic        cmd_berr_q, cmd_berr_d;
  logic [31:0] cmd_rd_q, cmd_rd_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        align_err;
  logic        timeout_hit;
  logic [3:0]  lanes;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  // CE_F only marks when the slave drives read data; nothing here samples on it.
  logic unused_ce_f;
  assign unused_ce_f = CE_F;

  always_comb begin
    align_err = (CMD_SZ == 2'd3) ||
                ((CMD_SZ == 2'd1) && CMD_A[0]) ||
                ((CMD_SZ == 2'd2) && (CMD_A[1:0] != 2'b00));
  end

  always_comb begin
    lanes   = 4'b1111;
    wr_data = CMD_WD;
    case (CMD_SZ)
      2'd0: begin
        lanes   = 4'b1000 >> CMD_A[1:0];
        wr_data = {4{CMD_WD[7:0]}};
      end
      2'd1: begin
        lanes   = CMD_A[1] ? 4'b0011 : 4'b1100;
        wr_data = {2{CMD_WD[15:0]}};
      end
      default: ;
    endcase
  end

  // The registered lane mask alone identifies which DI bytes to return.
  always_comb begin
    case (ibus_ba_q)
      4'b1000: rd_data = {24'd0, ibus.IBUS_DI[31:24]};
      4'b0100: rd_data = {24'd0, ibus.IBUS_DI[23:16]};
      4'b0010: rd_data = {24'd0, ibus.IBUS_DI[15:8]};
      4'b0001: rd_data = {24'd0, ibus.IBUS_DI[7:0]};
      4'b1100: rd_data = {16'd0, ibus.IBUS_DI[31:16]};
      4'b0011: rd_data = {16'd0, ibus.IBUS_DI[15:0]};
      default: rd_data = ibus.IBUS_DI;
    endcase
  end

`ifdef IBUS_TIMEOUT_EN
  always_comb begin
    timeout_hit = ibus.IBUS_BUSY && (tmo_cnt_q == 8'(TIMEOUT - 1));
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ibus_a_q   <= '0;
      ibus_do_q  <= '0;
      ibus_ba_q  <= '0;
      ibus_we_q  <= 1'b0;
      ibus_req_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      cmd_aerr_q <= 1'b0;
      cmd_berr_q <= 1'b0;
      cmd_rd_q   <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ibus_a_q   <= ibus_a_d;
      ibus_do_q  <= ibus_do_d;
      ibus_ba_q  <= ibus_ba_d;
      ibus_we_q  <= ibus_we_d;
      ibus_req_q <= ibus_req_d;
      cmd_ack_q  <= cmd_ack_d;
      cmd_aerr_q <= cmd_aerr_d;
      cmd_berr_q <= cmd_berr_d;
      cmd_rd_q   <= cmd_rd_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (CE_R) begin
      if (!RES_N) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: if (CMD_REQ && !align_err) state_d = BUS;
          BUS:  if (!ibus.IBUS_BUSY || timeout_hit) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output/datapath logic; status flags default low so they last one CLK.
  always_comb begin
    ibus_a_d   = ibus_a_q;
    ibus_do_d  = ibus_do_q;
    ibus_ba_d  = ibus_ba_q;
    ibus_we_d  = ibus_we_q;
    ibus_req_d = ibus_req_q;
    cmd_ack_d  = 1'b0;
    cmd_aerr_d = 1'b0;
    cmd_berr_d = 1'b0;
    cmd_rd_d   = cmd_rd_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (CE_R) begin
      if (!RES_N) begin
        ibus_a_d   = '0;
        ibus_do_d  = '0;
        ibus_ba_d  = '0;
        ibus_we_d  = 1'b0;
        ibus_req_d = 1'b0;
        tmo_cnt_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (CMD_REQ) begin
              if (align_err) begin
                cmd_ack_d  = 1'b1;
                cmd_aerr_d = 1'b1;
                cmd_rd_d   = '0;
              end else begin
                ibus_a_d   = CMD_A;
                ibus_do_d  = CMD_WE ? wr_data : '0;
                ibus_ba_d  = lanes;
                ibus_we_d  = CMD_WE;
                ibus_req_d = 1'b1;
                tmo_cnt_d  = '0;
              end
            end
          end
          BUS: begin
            if (!ibus.IBUS_BUSY || timeout_hit) begin
              cmd_ack_d  = 1'b1;
              cmd_berr_d = ibus.IBUS_BUSY;
              cmd_rd_d   = (ibus.IBUS_BUSY || ibus_we_q) ? '0 : rd_data;
              ibus_a_d   = '0;
              ibus_do_d  = '0;
              ibus_ba_d  = '0;
              ibus_we_d  = 1'b0;
              ibus_req_d = 1'b0;
            end else begin
`ifdef IBUS_TIMEOUT_EN
              tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ibus.IBUS_A   = ibus_a_q;
  assign ibus.IBUS_DO  = ibus_do_q;
  assign ibus.IBUS_BA  = ibus_ba_q;
  assign ibus.IBUS_WE  = ibus_we_q;
  assign ibus.IBUS_REQ = ibus_req_q;
  assign CMD_ACK       = cmd_ack_q;
  assign CMD_AERR      = cmd_aerr_q;
  assign CMD_BERR      = cmd_berr_q;
  assign CMD_RD        = cmd_rd_q;

endmodule

// File: tb/tb_ibus_initiator.sv
// Directed bench for ibus_initiator; CE_R/CE_F alternate on successive CLK cycles.
// With IBUS_TIMEOUT_EN defined the DUT is built with TIMEOUT=4.
module tb_ibus_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_r = 1'b0;
  logic        ce_f = 1'b0;
  logic        res_n = 1'b1;
  logic        cmd_req = 1'b0;
  logic [27:0] cmd_a = '0;
  logic        cmd_we = 1'b0;
  logic [1:0]  cmd_sz = '0;
  logic [31:0] cmd_wd = '0;
  logic        cmd_ack;
  logic [31:0] cmd_rd;
  logic        cmd_aerr;
  logic        cmd_berr;

  int n_checks = 0;
  int n_fail = 0;

  ibus_initiator_if bus ();

  ibus_initiator #(.TIMEOUT(4)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CE_R     (ce_r),
    .CE_F     (ce_f),
    .RES_N    (res_n),
    .CMD_REQ  (cmd_req),
    .CMD_A    (cmd_a),
    .CMD_WE   (cmd_we),
    .CMD_SZ   (cmd_sz),
    .CMD_WD   (cmd_wd),
    .CMD_ACK  (cmd_ack),
    .CMD_RD   (cmd_rd),
    .CMD_AERR (cmd_aerr),
    .CMD_BERR (cmd_berr),
    .ibus     (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ce_r = ~ce_r;
        ce_f = ~ce_r;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ce_step();
    do @(posedge clk); while (!ce_r);
    #1;
  endtask

  task automatic issue(input logic [27:0] a, input logic we, input logic [1:0] sz,
                       input logic [31:0] wd);
    cmd_a   = a;
    cmd_we  = we;
    cmd_sz  = sz;
    cmd_wd  = wd;
    cmd_req = 1'b1;
  endtask

  logic ack_seen;

  initial begin
    bus.IBUS_DI   = '0;
    bus.IBUS_BUSY = 1'b0;
    #12;
    chk("rst_ack", {31'd0, cmd_ack}, 32'd0);
    chk("rst_rd", cmd_rd, 32'd0);
    chk("rst_errs", {30'd0, cmd_aerr, cmd_berr}, 32'd0);
    chk("rst_req", {31'd0, bus.IBUS_REQ}, 32'd0);
    chk("rst_bus", {bus.IBUS_BA, bus.IBUS_A}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte write, lane 1
    issue(28'h5FFFF91, 1'b1, 2'd0, 32'h0000_00A5);
    ce_step();
    chk("bw_req", {31'd0, bus.IBUS_REQ}, 32'd1);
    chk("bw_ba", {28'd0, bus.IBUS_BA}, 32'h4);
    chk("bw_do", bus.IBUS_DO, 32'hA5A5_A5A5);
    chk("bw_we", {31'd0, bus.IBUS_WE}, 32'd1);
    chk("bw_a", {4'd0, bus.IBUS_A}, 32'h05FF_FF91);
    chk("bw_noack", {31'd0, cmd_ack}, 32'd0);
    ce_step();
    chk("bw_ack", {29'd0, cmd_ack, cmd_aerr, cmd_berr}, 32'h4);
    chk("bw_req_low", {31'd0, bus.IBUS_REQ}, 32'd0);
    chk("bw_rd", cmd_rd, 32'd0);
    cmd_req = 1'b0;
    @(posedge clk); #1;
    chk("bw_ack_pulse", {31'd0, cmd_ack}, 32'd0);

    // Long read
    bus.IBUS_DI = 32'h1234_5678;
    ce_step();
    issue(28'h5FFFF94, 1'b0, 2'd2, 32'hFFFF_FFFF);
    ce_step();
    chk("lr_ba", {28'd0, bus.IBUS_BA}, 32'hF);
    chk("lr_do", bus.IBUS_DO, 32'd0);
    chk("lr_we", {31'd0, bus.IBUS_WE}, 32'd0);
    ce_step();
    chk("lr_ack", {29'd0, cmd_ack, cmd_aerr, cmd_berr}, 32'h4);
    chk("lr_rd", cmd_rd, 32'h1234_5678);
    cmd_req = 1'b0;
    ce_step();
    chk("lr_rd_hold", cmd_rd, 32'h1234_5678);

    // Word read, lanes 1:0
    issue(28'h5FFFF96, 1'b0, 2'd1, 32'd0);
    ce_step();
    chk("wr16_ba", {28'd0, bus.IBUS_BA}, 32'h3);
    ce_step();
    chk("wr16_rd", cmd_rd, 32'h0000_5678);
    cmd_req = 1'b0;
    ce_step();

    // Byte read, lane 3
    issue(28'h5FFFF93, 1'b0, 2'd0, 32'd0);
    ce_step();
    chk("br3_ba", {28'd0, bus.IBUS_BA}, 32'h1);
    ce_step();
    chk("br3_rd", cmd_rd, 32'h0000_0078);
    cmd_req = 1'b0;
    ce_step();

    // Word write, upper half
    issue(28'h5FFFF90, 1'b1, 2'd1, 32'hFFFF_BEEF);
    ce_step();
    chk("ww_ba", {28'd0, bus.IBUS_BA}, 32'hC);
    chk("ww_do", bus.IBUS_DO, 32'hBEEF_BEEF);
    ce_step();
    chk("ww_ack", {31'd0, cmd_ack}, 32'd1);
    cmd_req = 1'b0;
    ce_step();

    // Alignment errors: word odd, long offset 2, reserved size
    issue(28'h5FFFF95, 1'b0, 2'd1, 32'd0);
    ce_step();
    chk("ae_word", {29'd0, cmd_ack, cmd_aerr, bus.IBUS_REQ}, 32'h6);
    cmd_req = 1'b0;
    ce_step();
    issue(28'h5FFFF96, 1'b1, 2'd2, 32'h1111_1111);
    ce_step();
    chk("ae_long", {29'd0, cmd_ack, cmd_aerr, bus.IBUS_REQ}, 32'h6);
    cmd_req = 1'b0;
    ce_step();
    chk("ae_long_idle", {31'd0, bus.IBUS_REQ}, 32'd0);
    issue(28'h5FFFF94, 1'b0, 2'd3, 32'd0);
    ce_step();
    chk("ae_sz3", {29'd0, cmd_ack, cmd_aerr, bus.IBUS_REQ}, 32'h6);
    chk("ae_rd", cmd_rd, 32'd0);
    cmd_req = 1'b0;
    ce_step();

    // Read stretched by three busy samples
    bus.IBUS_BUSY = 1'b1;
    bus.IBUS_DI   = 32'hDEAD_BEEF;
    issue(28'h5FFFF94, 1'b0, 2'd2, 32'd0);
    ce_step();
    for (int i = 0; i < 3; i++) begin
      ce_step();
      chk($sformatf("busy_hold%0d", i), {bus.IBUS_REQ, bus.IBUS_BA, cmd_ack, bus.IBUS_A[25:0]},
          {1'b1, 4'hF, 1'b0, 26'h1FFFF94});
      chk($sformatf("busy_rd%0d", i), cmd_rd, 32'd0);
    end
    bus.IBUS_BUSY = 1'b0;
    bus.IBUS_DI   = 32'hCAFE_F00D;
    ce_step();
    chk("busy_ack", {29'd0, cmd_ack, cmd_aerr, cmd_berr}, 32'h4);
    chk("busy_rd", cmd_rd, 32'hCAFE_F00D);
    cmd_req = 1'b0;
    ce_step();

    // Slave stuck busy
    bus.IBUS_BUSY = 1'b1;
    issue(28'h5FFFF94, 1'b0, 2'd2, 32'd0);
    ce_step();
`ifdef IBUS_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      ce_step();
      chk($sformatf("tmo_wait%0d", i), {30'd0, cmd_ack, bus.IBUS_REQ}, 32'h1);
    end
    ce_step();
    chk("tmo_ack", {29'd0, cmd_ack, cmd_aerr, cmd_berr}, 32'h5);
    chk("tmo_req", {31'd0, bus.IBUS_REQ}, 32'd0);
    chk("tmo_rd", cmd_rd, 32'd0);
    cmd_req = 1'b0;
    ce_step();
`else
    ack_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ce_step();
      ack_seen = ack_seen | cmd_ack | cmd_berr;
    end
    chk("stuck_noack", {31'd0, ack_seen}, 32'd0);
    chk("stuck_req", {31'd0, bus.IBUS_REQ}, 32'd1);
    res_n   = 1'b0;
    cmd_req = 1'b0;
    ce_step();
    res_n = 1'b1;
    chk("stuck_reset", {30'd0, bus.IBUS_REQ, cmd_ack}, 32'd0);
`endif

    // Soft reset during a busy cycle, then a fresh command
    issue(28'h5FFFF90, 1'b0, 2'd0, 32'd0);
    ce_step();
    ce_step();
    chk("sr_req_pre", {31'd0, bus.IBUS_REQ}, 32'd1);
    res_n   = 1'b0;
    cmd_req = 1'b0;
    ce_step();
    chk("sr_abort", {26'd0, bus.IBUS_REQ, cmd_ack, bus.IBUS_BA}, 32'd0);
    res_n = 1'b1;
    bus.IBUS_BUSY = 1'b0;
    issue(28'h5FFFF98, 1'b1, 2'd2, 32'h1122_3344);
    ce_step();
    chk("sr_new_req", {27'd0, bus.IBUS_REQ, bus.IBUS_BA}, 32'h1F);
    chk("sr_new_do", bus.IBUS_DO, 32'h1122_3344);
    ce_step();
    chk("sr_new_ack", {29'd0, cmd_ack, cmd_aerr, cmd_berr}, 32'h4);
    cmd_req = 1'b0;
    ce_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
